// File: rtl/tvip_axi_protocol_checker.sv
// tvip_axi_protocol_checker: passive AXI4 checker for handshake stability, W-burst length, response ordering and outstanding limits
module tvip_axi_protocol_checker #(
  parameter int ID_WIDTH = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTSTANDING = 8,
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       aclk,
  input  logic                       areset_n,
  input  logic                       awvalid,
  input  logic                       awready,
  input  logic [ID_WIDTH-1:0]        awid,
  input  logic [ADDRESS_WIDTH-1:0]   awaddr,
  input  logic [7:0]                 awlen,
  input  logic [2:0]                 awsize,
  input  logic [1:0]                 awburst,
  input  logic [3:0]                 awcache,
  input  logic [2:0]                 awprot,
  input  logic [3:0]                 awqos,
  input  logic                       wvalid,
  input  logic                       wready,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [DATA_WIDTH/8-1:0]    wstrb,
  input  logic                       wlast,
  input  logic                       bvalid,
  input  logic                       bready,
  input  logic [ID_WIDTH-1:0]        bid,
  input  logic [1:0]                 bresp,
  input  logic                       arvalid,
  input  logic                       arready,
  input  logic [ID_WIDTH-1:0]        arid,
  input  logic [ADDRESS_WIDTH-1:0]   araddr,
  input  logic [7:0]                 arlen,
  input  logic [2:0]                 arsize,
  input  logic [1:0]                 arburst,
  input  logic [3:0]                 arcache,
  input  logic [2:0]                 arprot,
  input  logic [3:0]                 arqos,
  input  logic                       rvalid,
  input  logic                       rready,
  input  logic [ID_WIDTH-1:0]        rid,
  input  logic [DATA_WIDTH-1:0]      rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rlast,
  input  logic                       clear_errors,
  output logic [10:0]                error_status,
  output logic [10:0]                error_pulse,
  output logic [CNT_WIDTH-1:0]       write_outstanding,
  output logic [CNT_WIDTH-1:0]       read_outstanding
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int AWP = ID_WIDTH + ADDRESS_WIDTH + 24;
  localparam int WP = DATA_WIDTH + DATA_WIDTH / 8 + 1;
  localparam int BP = ID_WIDTH + 2;
  localparam int RP = ID_WIDTH + DATA_WIDTH + 3;
  localparam logic [CNT_WIDTH-1:0] MAXC = CNT_WIDTH'(MAX_OUTSTANDING);
  logic [AWP-1:0] aw_p_d, aw_p_q, ar_p_d, ar_p_q;
  logic [WP-1:0] w_p_d, w_p_q;
  logic [BP-1:0] b_p_d, b_p_q;
  logic [RP-1:0] r_p_d, r_p_q;
  logic [4:0] stalled_d, stalled_q, stab_err;
  logic [7:0] fifo_d [MAX_OUTSTANDING];
  logic [7:0] fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0] wr_d, wr_q, rd_d, rd_q;
  logic [CNT_WIDTH-1:0] fifo_cnt_d, fifo_cnt_q, wr_done_d, wr_done_q;
  logic [CNT_WIDTH-1:0] wo_d, wo_q, ro_d, ro_q;
  logic [7:0] beat_d, beat_q, head;
  logic [10:0] err, status_d, status_q, pulse_d, pulse_q;
  logic armed_d, armed_q;
  logic aw_hs, ar_hs, w_hs, w_trk, w_final, aw_push, ar_inc, b_hs, b_unexp, b_dec, rl_hs, r_unexp, r_dec;
  logic aw_ovf, ar_ovf, wl_early, wl_missing, w_before_aw;
  // Capture stall state and payload; flag a stalled channel whose valid drops or payload moves
  always_comb begin
    aw_p_d = {awid, awaddr, awlen, awsize, awburst, awcache, awprot, awqos};
    ar_p_d = {arid, araddr, arlen, arsize, arburst, arcache, arprot, arqos};
    w_p_d = {wdata, wstrb, wlast};
    b_p_d = {bid, bresp};
    r_p_d = {rid, rdata, rresp, rlast};
    stalled_d = {rvalid & ~rready, arvalid & ~arready, bvalid & ~bready, wvalid & ~wready, awvalid & ~awready};
    stab_err[0] = stalled_q[0] & (~awvalid | (aw_p_d != aw_p_q));
    stab_err[1] = stalled_q[1] & (~wvalid | (w_p_d != w_p_q));
    stab_err[2] = stalled_q[2] & (~bvalid | (b_p_d != b_p_q));
    stab_err[3] = stalled_q[3] & (~arvalid | (ar_p_d != ar_p_q));
    stab_err[4] = stalled_q[4] & (~rvalid | (r_p_d != r_p_q));
  end
  // Burst length tracking, ordering checks, outstanding counters and error reporting
  always_comb begin
    head = fifo_q[rd_q];
    aw_hs = awvalid & awready;
    ar_hs = arvalid & arready;
    w_hs = wvalid & wready;
    b_hs = bvalid & bready;
    rl_hs = rvalid & rready & rlast;
    w_before_aw = w_hs & (fifo_cnt_q == '0);
    w_trk = w_hs & ~w_before_aw;
    w_final = w_trk & ((beat_q == head) | wlast);
    wl_early = w_trk & wlast & (beat_q < head);
    wl_missing = w_trk & ~wlast & (beat_q == head);
    aw_ovf = aw_hs & (wo_q == MAXC);
    ar_ovf = ar_hs & (ro_q == MAXC);
    aw_push = aw_hs & ~aw_ovf;
    ar_inc = ar_hs & ~ar_ovf;
    b_unexp = b_hs & (wr_done_q == '0) & ~w_final;
    b_dec = b_hs & ~b_unexp & (wo_q != '0);
    r_unexp = rl_hs & (ro_q == '0);
    r_dec = rl_hs & ~r_unexp;
    fifo_d = fifo_q;
    if (aw_push) fifo_d[wr_q] = awlen;
    wr_d = wr_q + PW'(aw_push);
    rd_d = rd_q + PW'(w_final);
    fifo_cnt_d = fifo_cnt_q + CNT_WIDTH'(aw_push) - CNT_WIDTH'(w_final);
    beat_d = w_final ? 8'd0 : w_trk ? beat_q + 8'd1 : beat_q;
    wr_done_d = wr_done_q + CNT_WIDTH'(w_final) - CNT_WIDTH'(b_dec);
    wo_d = wo_q + CNT_WIDTH'(aw_push) - CNT_WIDTH'(b_dec);
    ro_d = ro_q + CNT_WIDTH'(ar_inc) - CNT_WIDTH'(r_dec);
    err = {w_before_aw, aw_ovf | ar_ovf, r_unexp, b_unexp, wl_missing, wl_early, stab_err} & {11{armed_q}};
    pulse_d = err;
    status_d = (clear_errors ? 11'd0 : status_q) | err;
    armed_d = 1'b1;
  end
  // State registers with asynchronous active-low reset
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      aw_p_q <= '0;
      ar_p_q <= '0;
      w_p_q <= '0;
      b_p_q <= '0;
      r_p_q <= '0;
      stalled_q <= '0;
      fifo_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      fifo_cnt_q <= '0;
      beat_q <= '0;
      wr_done_q <= '0;
      wo_q <= '0;
      ro_q <= '0;
      status_q <= '0;
      pulse_q <= '0;
      armed_q <= 1'b0;
    end else begin
      aw_p_q <= aw_p_d;
      ar_p_q <= ar_p_d;
      w_p_q <= w_p_d;
      b_p_q <= b_p_d;
      r_p_q <= r_p_d;
      stalled_q <= stalled_d;
      fifo_q <= fifo_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      fifo_cnt_q <= fifo_cnt_d;
      beat_q <= beat_d;
      wr_done_q <= wr_done_d;
      wo_q <= wo_d;
      ro_q <= ro_d;
      status_q <= status_d;
      pulse_q <= pulse_d;
      armed_q <= armed_d;
    end
  end
  assign error_status = status_q;
  assign error_pulse = pulse_q;
  assign write_outstanding = wo_q;
  assign read_outstanding = ro_q;
endmodule

// File: tb/tb_tvip_axi_protocol_checker.sv
// tb_tvip_axi_protocol_checker: directed and randomized checks of the AXI protocol checker against a queue-based model
module tb_tvip_axi_protocol_checker;
  localparam int MAXO = 8;
  logic aclk = 1'b0;
  logic areset_n = 1'b0;
  logic awvalid = 0, awready = 0, wvalid = 0, wready = 0, wlast = 0, bvalid = 0, bready = 0;
  logic arvalid = 0, arready = 0, rvalid = 0, rready = 0, rlast = 0, clear_errors = 0;
  logic [3:0] awid = 0, bid = 0, arid = 0, rid = 0, awcache = 0, awqos = 0, arcache = 0, arqos = 0, wstrb = 0;
  logic [31:0] awaddr = 0, araddr = 0, wdata = 0, rdata = 0;
  logic [7:0] awlen = 0, arlen = 0;
  logic [2:0] awsize = 0, awprot = 0, arsize = 0, arprot = 0;
  logic [1:0] awburst = 0, arburst = 0, bresp = 0, rresp = 0;
  logic [10:0] error_status, error_pulse;
  logic [3:0] write_outstanding, read_outstanding;
  int checks = 0;
  int errors = 0;
  int m_wo, m_ro, m_done, m_beat;
  int m_q[$];
  logic [10:0] m_status, m_pulse;
  bit m_armed;
  bit s_aw, s_w, s_b, s_ar, s_r;
  logic [59:0] p_aw, p_ar;
  logic [36:0] p_w;
  logic [5:0] p_b;
  logic [38:0] p_r;

  always #5 aclk = ~aclk;

  tvip_axi_protocol_checker #(.ID_WIDTH(4), .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAXO)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awcache(awcache), .awprot(awprot), .awqos(awqos),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arcache(arcache), .arprot(arprot), .arqos(arqos),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .clear_errors(clear_errors), .error_status(error_status), .error_pulse(error_pulse),
    .write_outstanding(write_outstanding), .read_outstanding(read_outstanding)
  );

  task automatic mreset();
    m_wo = 0; m_ro = 0; m_done = 0; m_beat = 0; m_q.delete();
    m_status = '0; m_pulse = '0; m_armed = 0;
    s_aw = 0; s_w = 0; s_b = 0; s_ar = 0; s_r = 0;
    p_aw = '0; p_ar = '0; p_w = '0; p_b = '0; p_r = '0;
  endtask

  task automatic model_step();
    logic [10:0] e;
    logic [59:0] awn, arn;
    logic [36:0] wn;
    logic [5:0] bn;
    logic [38:0] rn;
    bit fin, bl, rdec;
    e = '0; fin = 0; rdec = 0;
    awn = {awid, awaddr, awlen, awsize, awburst, awcache, awprot, awqos};
    arn = {arid, araddr, arlen, arsize, arburst, arcache, arprot, arqos};
    wn = {wdata, wstrb, wlast};
    bn = {bid, bresp};
    rn = {rid, rdata, rresp, rlast};
    if (s_aw && (!awvalid || awn !== p_aw)) e[0] = 1;
    if (s_w && (!wvalid || wn !== p_w)) e[1] = 1;
    if (s_b && (!bvalid || bn !== p_b)) e[2] = 1;
    if (s_ar && (!arvalid || arn !== p_ar)) e[3] = 1;
    if (s_r && (!rvalid || rn !== p_r)) e[4] = 1;
    if (wvalid && wready) begin
      if (m_q.size() == 0) e[10] = 1;
      else begin
        if (wlast && m_beat < m_q[0]) e[5] = 1;
        if (!wlast && m_beat == m_q[0]) e[6] = 1;
        if (wlast || m_beat == m_q[0]) begin
          void'(m_q.pop_front());
          m_beat = 0;
          fin = 1;
        end else m_beat++;
      end
    end
    bl = bvalid && bready && (m_done > 0 || fin);
    if (bvalid && bready && !bl) e[7] = 1;
    if (awvalid && awready) begin
      if (m_wo == MAXO) e[9] = 1;
      else begin
        m_q.push_back(int'(awlen));
        m_wo++;
      end
    end
    if (bl) m_wo--;
    if (fin) m_done++;
    if (bl) m_done--;
    if (rvalid && rready && rlast) begin
      if (m_ro == 0) e[8] = 1;
      else rdec = 1;
    end
    if (arvalid && arready) begin
      if (m_ro == MAXO) e[9] = 1;
      else m_ro++;
    end
    if (rdec) m_ro--;
    if (!m_armed) e = '0;
    m_armed = 1;
    m_status = (clear_errors ? 11'd0 : m_status) | e;
    m_pulse = e;
    s_aw = awvalid && !awready; s_w = wvalid && !wready; s_b = bvalid && !bready;
    s_ar = arvalid && !arready; s_r = rvalid && !rready;
    p_aw = awn; p_ar = arn; p_w = wn; p_b = bn; p_r = rn;
  endtask

  task automatic tick();
    model_step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    awvalid = 0; awready = 0; wvalid = 0; wready = 0; wlast = 0; bvalid = 0; bready = 0;
    arvalid = 0; arready = 0; rvalid = 0; rready = 0; rlast = 0; clear_errors = 0;
  endtask

  task automatic do_reset();
    idle();
    areset_n = 0;
    mreset();
    @(posedge aclk);
    @(negedge aclk);
    areset_n = 1;
    tick();
  endtask

  task automatic send_aw(input logic [7:0] len);
    awvalid = 1; awready = 1; awlen = len; awaddr = $urandom;
    tick();
    awvalid = 0; awready = 0;
  endtask

  task automatic send_w(input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      wvalid = 1; wready = 1; wdata = $urandom; wstrb = 4'hf; wlast = (i == last_at);
      tick();
    end
    wvalid = 0; wready = 0; wlast = 0;
  endtask

  task automatic test_reset();
    idle();
    mreset();
    #12;
    checks++;
    if ({error_status, error_pulse, write_outstanding, read_outstanding} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h/%h/%0d/%0d want 0", error_status, error_pulse, write_outstanding, read_outstanding);
    end
    @(negedge aclk);
    areset_n = 1;
    bvalid = 1; bready = 1;
    tick();
    idle();
    checks++;
    if (error_pulse !== 11'h0 || error_status !== 11'h0) begin
      errors++;
      $display("FAIL first_cycle_quiet got pulse %h status %h want 0", error_pulse, error_status);
    end
    tick();
  endtask

  task automatic test_aw_stability();
    do_reset();
    awvalid = 1; awready = 0; awaddr = 32'h100;
    tick();
    awaddr = 32'h104;
    tick();
    checks++;
    if (error_pulse !== 11'h001) begin errors++; $display("FAIL aw_stab_pulse got %h want 001", error_pulse); end
    checks++;
    if (error_status !== 11'h001) begin errors++; $display("FAIL aw_stab_status got %h want 001", error_status); end
    awready = 1;
    tick();
    idle();
    tick();
    checks++;
    if (error_pulse !== 11'h0 || error_status !== 11'h001) begin
      errors++;
      $display("FAIL aw_stab_sticky got pulse %h status %h want 000/001", error_pulse, error_status);
    end
    clear_errors = 1;
    tick();
    clear_errors = 0;
    checks++;
    if (error_status !== 11'h0) begin errors++; $display("FAIL clear_errors got %h want 000", error_status); end
    awvalid = 1; awready = 0; awaddr = 32'h200;
    tick();
    awaddr = 32'h204; clear_errors = 1;
    tick();
    idle();
    checks++;
    if (error_status !== 11'h001) begin errors++; $display("FAIL clear_vs_set got %h want 001", error_status); end
  endtask

  task automatic test_legal_burst();
    do_reset();
    send_aw(8'd3);
    checks++;
    if (write_outstanding !== 4'd1) begin errors++; $display("FAIL burst_wo_after_aw got %0d want 1", write_outstanding); end
    send_w(4, 3);
    bvalid = 1; bready = 1;
    tick();
    idle();
    checks++;
    if (write_outstanding !== 4'd0) begin errors++; $display("FAIL burst_wo_after_b got %0d want 0", write_outstanding); end
    checks++;
    if (error_status !== 11'h0) begin errors++; $display("FAIL burst_status got %h want 000", error_status); end
  endtask

  task automatic test_length_errors();
    do_reset();
    send_aw(8'd3);
    send_w(2, 1);
    checks++;
    if (error_pulse !== 11'h020) begin errors++; $display("FAIL wlast_early got %h want 020", error_pulse); end
    do_reset();
    send_aw(8'd1);
    send_w(2, 9);
    checks++;
    if (error_pulse !== 11'h040) begin errors++; $display("FAIL wlast_missing got %h want 040", error_pulse); end
  endtask

  task automatic test_ordering();
    do_reset();
    bvalid = 1; bready = 1;
    tick();
    idle();
    checks++;
    if (error_pulse !== 11'h080) begin errors++; $display("FAIL b_unexpected got %h want 080", error_pulse); end
    do_reset();
    rvalid = 1; rready = 1; rlast = 1;
    tick();
    idle();
    checks++;
    if (error_pulse !== 11'h100) begin errors++; $display("FAIL r_unexpected got %h want 100", error_pulse); end
    do_reset();
    send_w(1, 0);
    checks++;
    if (error_pulse !== 11'h400) begin errors++; $display("FAIL w_before_aw got %h want 400", error_pulse); end
    do_reset();
    send_aw(8'd0);
    wvalid = 1; wready = 1; wlast = 1; bvalid = 1; bready = 1;
    tick();
    idle();
    checks++;
    if (error_status !== 11'h0 || write_outstanding !== 4'd0) begin
      errors++;
      $display("FAIL w_and_b_same_cycle got status %h wo %0d want 000/0", error_status, write_outstanding);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    arvalid = 1; arready = 1;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (read_outstanding !== 4'd8 || error_pulse !== 11'h0) begin
      errors++;
      $display("FAIL ar_fill got ro %0d pulse %h want 8/000", read_outstanding, error_pulse);
    end
    tick();
    arvalid = 0; arready = 0;
    checks++;
    if (error_pulse !== 11'h200) begin errors++; $display("FAIL ar_overflow got %h want 200", error_pulse); end
    checks++;
    if (read_outstanding !== 4'd8) begin errors++; $display("FAIL ro_saturate got %0d want 8", read_outstanding); end
    rvalid = 1; rready = 1; rlast = 1;
    tick();
    idle();
    checks++;
    if (read_outstanding !== 4'd7 || error_pulse !== 11'h0) begin
      errors++;
      $display("FAIL ro_decrement got ro %0d pulse %h want 7/000", read_outstanding, error_pulse);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bvalid = 1; bready = 1;
    tick();
    bvalid = 0; bready = 0;
    send_aw(8'd3);
    wvalid = 1; wready = 1; wlast = 0;
    tick();
    tick();
    areset_n = 0;
    mreset();
    #1;
    checks++;
    if ({error_status, error_pulse, write_outstanding, read_outstanding} !== '0) begin
      errors++;
      $display("FAIL reset_mid_burst got %h/%h/%0d/%0d want 0", error_status, error_pulse, write_outstanding, read_outstanding);
    end
    idle();
    @(negedge aclk);
    areset_n = 1;
    tick();
    send_aw(8'd3);
    send_w(4, 3);
    bvalid = 1; bready = 1;
    tick();
    idle();
    checks++;
    if (error_status !== 11'h0 || write_outstanding !== 4'd0) begin
      errors++;
      $display("FAIL fresh_burst got status %h wo %0d want 000/0", error_status, write_outstanding);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      if (!(awvalid && !awready && $urandom_range(0, 7) != 0)) begin
        awvalid = $urandom_range(0, 2) == 0; awid = $urandom; awaddr = $urandom; awlen = $urandom_range(0, 3);
        awsize = $urandom; awburst = $urandom; awcache = $urandom; awprot = $urandom; awqos = $urandom;
      end
      awready = $urandom_range(0, 1);
      if (!(wvalid && !wready && $urandom_range(0, 7) != 0)) begin
        wvalid = $urandom_range(0, 1); wdata = $urandom; wstrb = $urandom;
        wlast = ((m_q.size() > 0) && (m_beat == m_q[0])) ^ ($urandom_range(0, 9) == 0);
      end
      wready = $urandom_range(0, 1);
      if (!(bvalid && !bready && $urandom_range(0, 7) != 0)) begin
        bvalid = $urandom_range(0, 3) == 0; bid = $urandom; bresp = $urandom;
      end
      bready = $urandom_range(0, 1);
      if (!(arvalid && !arready && $urandom_range(0, 7) != 0)) begin
        arvalid = $urandom_range(0, 2) == 0; arid = $urandom; araddr = $urandom; arlen = $urandom;
        arsize = $urandom; arburst = $urandom; arcache = $urandom; arprot = $urandom; arqos = $urandom;
      end
      arready = $urandom_range(0, 1);
      if (!(rvalid && !rready && $urandom_range(0, 7) != 0)) begin
        rvalid = $urandom_range(0, 2) == 0; rid = $urandom; rdata = $urandom; rresp = $urandom; rlast = $urandom;
      end
      rready = $urandom_range(0, 1);
      clear_errors = $urandom_range(0, 19) == 0;
      tick();
      checks++;
      if (error_pulse !== m_pulse) begin errors++; $display("FAIL rand_pulse cyc %0d got %h want %h", n, error_pulse, m_pulse); end
      checks++;
      if (error_status !== m_status) begin errors++; $display("FAIL rand_status cyc %0d got %h want %h", n, error_status, m_status); end
      checks++;
      if (write_outstanding !== 4'(m_wo)) begin errors++; $display("FAIL rand_wo cyc %0d got %0d want %0d", n, write_outstanding, m_wo); end
      checks++;
      if (read_outstanding !== 4'(m_ro)) begin errors++; $display("FAIL rand_ro cyc %0d got %0d want %0d", n, read_outstanding, m_ro); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_aw_stability();
    test_legal_burst();
    test_length_errors();
    test_ordering();
    test_overflow();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
